// File: rtl/ws2812_rx_if.sv
// Pixel output channel of the WS2812 receiver: data word with a valid/ready
// handshake plus the event pulses.
interface ws2812_rx_if;
  logic [23:0] dout;
  logic        valid;
  logic        ready;
  logic        frame_end;
  logic        overrun;
  logic        err;

  modport master (output dout, valid, frame_end, overrun, err, input ready);
  modport slave  (input dout, valid, frame_end, overrun, err, output ready);
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 serial line decoder: measures high-pulse widths to recover bits,
// packs 24 bits into a GRB word, and detects latch gaps and line errors.
module ws2812_rx #(
  parameter int T_THRESH   = 15,
  parameter int T_LATCH    = 1250,
  parameter int T_HIGH_MAX = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  ws2812_rx_if.master bus
);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam logic [15:0] C_THRESH   = 16'(T_THRESH);
  localparam logic [15:0] C_LATCH    = 16'(T_LATCH);
  localparam logic [15:0] C_LATCH_M1 = 16'(T_LATCH - 1);
  localparam logic [15:0] C_HIGH_MAX = 16'(T_HIGH_MAX);

  state_t      r_state, w_state_next;
  logic        r_sync1, r_din_s, r_din_prev;
  logic [15:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [4:0]  r_bitcnt, w_bitcnt_next;
  logic [23:0] r_shift, w_shift_next;
  logic        r_err, w_err_next;
  logic        r_frame_end, w_frame_end_next;
  logic        w_offer;
  logic [23:0] w_word;
  logic        w_rise, w_fall, w_bit;
  logic [23:0] r_dout;
  logic        r_valid, r_overrun;

  assign w_rise    = r_din_s & ~r_din_prev;
  assign w_fall    = ~r_din_s & r_din_prev;
  assign w_bit     = (r_cnt >= C_THRESH);
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_word    = {r_shift[22:0], w_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 1'b0;
      r_din_s     <= 1'b0;
      r_din_prev  <= 1'b0;
      r_state     <= SYNC;
      r_cnt       <= 16'd0;
      r_bitcnt    <= 5'd0;
      r_shift     <= 24'd0;
      r_err       <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_sync1     <= din;
      r_din_s     <= r_sync1;
      r_din_prev  <= r_din_s;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bitcnt    <= w_bitcnt_next;
      r_shift     <= w_shift_next;
      r_err       <= w_err_next;
      r_frame_end <= w_frame_end_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_bitcnt_next    = r_bitcnt;
    w_shift_next     = r_shift;
    w_err_next       = 1'b0;
    w_frame_end_next = 1'b0;
    w_offer          = 1'b0;
    case (r_state)
      // Wait for a full latch gap so we never start decoding mid-frame.
      SYNC: begin
        if (r_din_s) begin
          w_cnt_next = 16'd0;
        end else if (r_cnt >= C_LATCH_M1) begin
          w_state_next = IDLE;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      IDLE: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_cnt_next   = 16'd1;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_shift_next = w_word;
          w_state_next = LOW;
          w_cnt_next   = 16'd1;
          if (r_bitcnt == 5'd23) begin
            w_bitcnt_next = 5'd0;
            w_offer       = 1'b1;
          end else begin
            w_bitcnt_next = r_bitcnt + 5'd1;
          end
        end else if (w_cnt_inc >= C_HIGH_MAX) begin
          w_err_next    = 1'b1;
          w_shift_next  = 24'd0;
          w_bitcnt_next = 5'd0;
          w_state_next  = SYNC;
          w_cnt_next    = 16'd0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_cnt_next   = 16'd1;
        end else if (w_cnt_inc >= C_LATCH) begin
          w_frame_end_next = 1'b1;
          w_state_next     = IDLE;
          w_cnt_next       = 16'd0;
          // A latch arriving mid-word means the frame was truncated.
          if (r_bitcnt != 5'd0) begin
            w_err_next    = 1'b1;
            w_shift_next  = 24'd0;
            w_bitcnt_next = 5'd0;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = SYNC;
        w_cnt_next   = 16'd0;
      end
    endcase
  end

  // Single-entry output register; a word arriving while one is still held is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout    <= 24'd0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_offer) begin
        if (!r_valid || bus.ready) begin
          r_dout  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.valid     = r_valid;
  assign bus.frame_end = r_frame_end;
  assign bus.overrun   = r_overrun;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected words and checks
// into queues, a negedge monitor pops and compares them.
module tb_ws2812_rx;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic din   = 1'b0;

  ws2812_rx_if bus();

  ws2812_rx dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    got;
    int    exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [23:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_fall = 0;

  int err_cnt = 0, fe_cnt = 0, ov_cnt = 0, fe_err_cnt = 0;
  int vhigh_cnt = 0, vrise_cnt = 0, hs_cnt = 0, vrise_cyc = 0;
  int b_err, b_fe, b_ov, b_fe_err, b_vhigh, b_vrise, b_hs;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: drains queued checks and scores every handshake.
  initial begin : monitor
    chk_t        c;
    logic [23:0] e;
    logic        valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_tests++;
        if (c.got != c.exp) begin
          n_fail++;
          $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", c.name, c.got, c.exp);
        end else begin
          $display("[TB] ok   %s = 0x%0h", c.name, c.got);
        end
      end
      if (bus.err)                 err_cnt++;
      if (bus.frame_end)           fe_cnt++;
      if (bus.overrun)             ov_cnt++;
      if (bus.err && bus.frame_end) fe_err_cnt++;
      if (bus.valid)               vhigh_cnt++;
      if (bus.valid && !valid_prev) begin
        vrise_cnt++;
        vrise_cyc = cyc;
      end
      valid_prev = bus.valid;
      if (bus.valid && bus.ready) begin
        hs_cnt++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL word: got 0x%06h, required no word", bus.dout);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout !== e) begin
            n_fail++;
            $display("[TB] FAIL word: got 0x%06h, required 0x%06h", bus.dout, e);
          end else begin
            $display("[TB] ok   word = 0x%06h", bus.dout);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int got, input int exp);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic hold(input logic lvl, input int n);
    din = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      hold(1'b1, v[i] ? 20 : 10);
      last_fall = cyc;
      hold(1'b0, v[i] ? 10 : 20);
    end
  endtask

  task automatic snap();
    b_err = err_cnt; b_fe = fe_cnt; b_ov = ov_cnt; b_fe_err = fe_err_cnt;
    b_vhigh = vhigh_cnt; b_vrise = vrise_cnt; b_hs = hs_cnt;
  endtask

  initial begin : stimulus
    bus.ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset values
    hold(1'b0, 5);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_frame_end", int'(bus.frame_end), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_err", int'(bus.err), 0);
    reset = 1'b1;

    // Single word, ready high
    bus.ready = 1'b1;
    hold(1'b0, 1300);
    snap();
    exp_q.push_back(24'hFF00FF);
    send_bits(24'hFF00FF, 24);
    hold(1'b0, 1260);
    check("A_latency", vrise_cyc - last_fall, 3);
    check("A_valid_cycles", vhigh_cnt - b_vhigh, 1);
    check("A_handshakes", hs_cnt - b_hs, 1);
    check("A_frame_end", fe_cnt - b_fe, 1);
    check("A_err", err_cnt - b_err, 0);
    check("A_overrun", ov_cnt - b_ov, 0);

    // Two words, ready low: second dropped
    bus.ready = 1'b0;
    snap();
    exp_q.push_back(24'h123456);
    send_bits(24'h123456, 24);
    send_bits(24'hABCDEF, 24);
    hold(1'b0, 1300);
    check("B_dout_held", int'(bus.dout), 32'h123456);
    check("B_valid_held", int'(bus.valid), 1);
    check("B_overrun", ov_cnt - b_ov, 1);
    check("B_frame_end", fe_cnt - b_fe, 1);
    check("B_no_handshake", hs_cnt - b_hs, 0);
    bus.ready = 1'b1;
    hold(1'b0, 3);
    check("B_valid_cleared", int'(bus.valid), 0);
    check("B_handshakes", hs_cnt - b_hs, 1);

    // Two words, ready high
    snap();
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'hABCDEF);
    send_bits(24'h123456, 24);
    send_bits(24'hABCDEF, 24);
    hold(1'b0, 1300);
    check("C_handshakes", hs_cnt - b_hs, 2);
    check("C_overrun", ov_cnt - b_ov, 0);
    check("C_frame_end", fe_cnt - b_fe, 1);

    // Over-long high pulse, then an ignored burst
    snap();
    hold(1'b1, 45);
    hold(1'b0, 10);
    send_bits(24'h000ABC, 12);
    hold(1'b0, 1300);
    check("D_err", err_cnt - b_err, 1);
    check("D_frame_end", fe_cnt - b_fe, 0);
    check("D_valid_rises", vrise_cnt - b_vrise, 0);
    exp_q.push_back(24'h5A5A5A);
    send_bits(24'h5A5A5A, 24);
    hold(1'b0, 1300);
    check("D_recover_hs", hs_cnt - b_hs, 1);
    check("D_recover_fe", fe_cnt - b_fe, 1);

    // Truncated word at latch
    snap();
    send_bits(24'h000F0F, 12);
    hold(1'b0, 1300);
    check("E_err", err_cnt - b_err, 1);
    check("E_frame_end", fe_cnt - b_fe, 1);
    check("E_same_cycle", fe_err_cnt - b_fe_err, 1);
    check("E_valid_rises", vrise_cnt - b_vrise, 0);

    // Reset mid-word
    snap();
    send_bits(24'h0003C3, 10);
    reset = 1'b0;
    hold(1'b0, 3);
    check("F_rst_dout", int'(bus.dout), 0);
    check("F_rst_valid", int'(bus.valid), 0);
    check("F_rst_pulses", int'({bus.err, bus.frame_end, bus.overrun}), 0);
    reset = 1'b1;
    hold(1'b0, 1300);
    exp_q.push_back(24'h0F0F0F);
    send_bits(24'h0F0F0F, 24);
    hold(1'b0, 1300);
    check("F_handshakes", hs_cnt - b_hs, 1);
    check("F_err", err_cnt - b_err, 0);

    check("sb_empty", exp_q.size(), 0);
    hold(1'b0, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
